// File: rtl/mips_mem_pkg.sv
// Shared memory-side definitions for the MIPS CPU: responder FSM states,
// latency counter width, request struct and error-cause encoding.
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

    localparam int LAT_CNT_W = 4;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    // aw is the word-index width; anything above the indexed bytes is out of range
    function automatic logic [1:0] dmem_err_cause(input logic [31:0] addr, input int unsigned aw);
        logic [1:0] c;
        c = '0;
        if (addr[1:0] != 2'b00) c = c | ERR_MISALIGN;
        if ((addr >> (aw + 2)) != 32'd0) c = c | ERR_RANGE;
        return c;
    endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Word-organised data RAM: synchronous byte-enabled write, asynchronous read,
// no reset (contents undefined until written).
module mips_dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/mips_dmem_responder.sv
// Fixed-latency data-memory responder for the MIPS MEM stage: one request at a
// time, one response pulse LATENCY cycles after acceptance.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e          state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t            req_q, req_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic [1:0]           cause_d, cause_q;
    logic [3:0]           wr_be;
    logic [31:0]          rd_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cause_d = dmem_err_cause(req_d.addr, AW);
        cause_q = dmem_err_cause(req_q.addr, AW);

        // Outputs are captured on entry to RESP; no store can land in between,
        // so reading one edge early returns the same word as a RESP-cycle read.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        resp_err_d   = resp_valid_d && (cause_d != 2'b00);
        resp_rdata_d = (resp_valid_d && !req_d.we && cause_d == 2'b00) ? rd_data : 32'd0;

        wr_be = (state_q == RESP && req_q.we && cause_q == 2'b00 && !reset) ? req_q.be : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    mips_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .wr_be  (wr_be),
        .wr_idx (req_q.addr[AW+1:2]),
        .wr_data(req_q.wdata),
        .rd_idx (req_d.addr[AW+1:2]),
        .rd_data(rd_data)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
